// File: rtl/pkt_buf_mem_pkg.sv
// Shared types and helpers for the packet-buffer memory responder.
package pkt_buf_mem_pkg;

  localparam int DWIDTH_DEF = 64;
  localparam int AWIDTH_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic even_par(input logic [DWIDTH_DEF-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/pkt_buf_mem_responder_if.sv
// MEMIF f0 port between the DMA FIFO (master) and the buffer memory (slave).
interface pkt_buf_mem_responder_if
  import pkt_buf_mem_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
);

  logic              write;
  logic [AWIDTH-1:0] waddr;
  logic [DWIDTH-1:0] wdata;
  logic [AWIDTH-1:0] raddr;
  logic              read;
  logic [DWIDTH-1:0] rdata;

  modport master (output write, waddr, wdata, raddr, read, input rdata);
  modport slave  (input write, waddr, wdata, raddr, read, output rdata);

endinterface

// File: rtl/pkt_buf_mem_responder.sv
// Packet-buffer storage with post-reset zero-fill, per-word even parity and
// parity-error detection, counting and first-error address capture.
module pkt_buf_mem_responder
  import pkt_buf_mem_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DEPTH  = 1 << AWIDTH,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  pkt_buf_mem_responder_if.slave   f0,
  output logic                     init_done,
  input  logic                     inj_err,
  input  logic                     clr_err,
  output logic                     par_err,
  output logic [CNT_W-1:0]         par_err_cnt,
  output logic [AWIDTH-1:0]        err_addr
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  state_t            state;
  logic [AWIDTH-1:0] init_ptr;
  logic              err_valid;
  logic [DWIDTH:0]   mem [DEPTH];
  logic [DWIDTH:0]   rd_word;
  logic              err_det;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      init_ptr  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == LAST_ADDR) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: ;
        default: state <= INIT;
      endcase
    end
  end

  // NOTE: the array has no reset; INIT zero-fills it, which keeps it mappable
  // onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_ptr] <= '0;
    end else if (f0.write) begin
      mem[f0.waddr] <= {even_par(f0.wdata) ^ inj_err, f0.wdata};
    end
  end

  // Zero-latency read so the FIFO sees data in the same cycle as its address.
  always_comb begin
    rd_word  = mem[f0.raddr];
    f0.rdata = (state == RUN) ? rd_word[DWIDTH-1:0] : '0;
    err_det  = (state == RUN) && f0.read &&
               (even_par(rd_word[DWIDTH-1:0]) != rd_word[DWIDTH]);
  end

  // A detection in the same cycle as clr_err takes priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err     <= 1'b0;
      par_err_cnt <= '0;
      err_addr    <= '0;
      err_valid   <= 1'b0;
    end else begin
      par_err <= err_det;
      if (err_det) begin
        if (clr_err)
          par_err_cnt <= CNT_W'(1);
        else if (par_err_cnt != '1)
          par_err_cnt <= par_err_cnt + 1'b1;
        if (!err_valid || clr_err) begin
          err_addr  <= f0.raddr;
          err_valid <= 1'b1;
        end
      end else if (clr_err) begin
        par_err_cnt <= '0;
        err_addr    <= '0;
        err_valid   <= 1'b0;
      end
    end
  end

  a_no_write_in_init : assert property (@(posedge clk) disable iff (rst)
    f0.write |-> init_done)
    else $warning("f0_write dropped while zero-fill in progress");

  a_rdata_zero_in_init : assert property (@(posedge clk) disable iff (rst)
    (state == INIT) |-> (f0.rdata == '0))
    else $error("f0_rdata nonzero during zero-fill");

endmodule
